// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared state encoding and NOP constant for the stall sequencer
package pipeline_stall_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
  assign cnt = r_cnt;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: merges hazard, mispredict, memory waits and halt drain into stage enables
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             is_hazard,
  input  logic             mispredict,
  input  logic             halt_req,
  input  logic             i_ready,
  input  logic             d_req,
  input  logic             d_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  state_t        r_state, w_next;
  logic [DW-1:0] r_drain, w_drain_next;
  logic          w_dmiss, w_run, w_flush_inc, w_stall_inc;
  assign w_dmiss = d_req & ~d_ready;
  assign w_run   = (r_state == ST_RUN) || (r_state == ST_DWAIT);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_next;
    end
  end
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_bubble = 1'b0;
    w_flush_inc   = 1'b0;
    w_next        = r_state;
    w_drain_next  = r_drain;
    if (!reset_n) begin
      w_next = ST_RUN;
    end else if (r_state == ST_HALTED) begin
      w_next = ST_HALTED;
    end else if (w_dmiss) begin
      // Every stage holds; mispredict/halt stay visible and are taken once memory completes.
      mem_wb_bubble = 1'b1;
      w_next        = (r_state == ST_DRAIN) ? ST_DRAIN : ST_DWAIT;
    end else if (r_state == ST_DRAIN) begin
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_write = 1'b1;
      w_drain_next = r_drain - 1'b1;
      w_next       = (r_drain == DW'(1)) ? ST_HALTED : ST_DRAIN;
    end else if (mispredict) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_write = 1'b1;
      w_flush_inc  = 1'b1;
      w_next       = ST_RUN;
    end else begin
      pc_write     = i_ready & ~is_hazard & ~halt_req;
      if_id_write  = ~is_hazard;
      if_id_flush  = ~i_ready | (~is_hazard & halt_req);
      id_ex_write  = 1'b1;
      id_ex_bubble = is_hazard;
      ex_mem_write = 1'b1;
      w_next       = (!is_hazard && halt_req) ? ST_DRAIN : ST_RUN;
      w_drain_next = (!is_hazard && halt_req) ? DRAIN_INIT : r_drain;
    end
  end
  assign halted      = (r_state == ST_HALTED);
  assign w_stall_inc = w_run & ~pc_write;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_stall_inc), .clr(1'b0), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_flush_inc), .clr(1'b0), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vectors with hand-computed enables and counter values
module tb_pipeline_stall_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        is_hazard = 1'b0, mispredict = 1'b0, halt_req = 1'b0;
  logic        i_ready = 1'b1, d_req = 1'b0, d_ready = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write;
  logic        id_ex_bubble, ex_mem_write, mem_wb_bubble, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic [7:0]  ctl;
  int          checks = 0, failures = 0;
  pipeline_stall_ctrl #(.CNT_W(32), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .is_hazard(is_hazard), .mispredict(mispredict),
    .halt_req(halt_req), .i_ready(i_ready), .d_req(d_req), .d_ready(d_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_bubble, ex_mem_write, mem_wb_bubble, halted};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // inputs {hz,mp,hr,ir,dq,dr}; ctl {pc,ifw,iff,idw,idb,exw,mwb,halted}
  task automatic cyc(input string tag, input logic [5:0] in, input logic [7:0] e_ctl,
                     input int e_stall, input int e_flush);
    {is_hazard, mispredict, halt_req, i_ready, d_req, d_ready} = in;
    #1;
    check({tag, ".ctl"}, {24'd0, ctl}, {24'd0, e_ctl});
    @(posedge clk);
    #1;
    check({tag, ".stall"}, stall_cnt, e_stall);
    check({tag, ".flush"}, flush_cnt, e_flush);
  endtask
  initial begin
    #2;
    check("rst.ctl", {24'd0, ctl}, 32'h0);
    check("rst.stall", stall_cnt, 32'd0);
    check("rst.flush", flush_cnt, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc("idle",     6'b000100, 8'hD4, 0, 0);
    cyc("hazard",   6'b100100, 8'h1C, 1, 0);
    for (int i = 0; i < 4; i++) cyc("dmiss", 6'b000110, 8'h02, 2 + i, 0);
    cyc("dready",   6'b000111, 8'hD4, 5, 0);
    cyc("run",      6'b000100, 8'hD4, 5, 0);
    cyc("mp_hz",    6'b110100, 8'hFC, 5, 1);
    cyc("mp_dmiss", 6'b010110, 8'h02, 6, 1);
    cyc("mp_drdy",  6'b010111, 8'hFC, 6, 2);
    cyc("no_iready",6'b000000, 8'h74, 7, 2);
    cyc("halt_acc", 6'b001100, 8'h74, 8, 2);
    cyc("drain1",   6'b000100, 8'h7C, 8, 2);
    cyc("drain_dm1",6'b000110, 8'h02, 8, 2);
    cyc("drain_dm2",6'b000110, 8'h02, 8, 2);
    cyc("drain2_mp",6'b010100, 8'h7C, 8, 2);
    cyc("drain3",   6'b000100, 8'h7C, 8, 2);
    cyc("halted",   6'b110100, 8'h01, 8, 2);
    cyc("halted2",  6'b001111, 8'h01, 8, 2);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc("halt2",    6'b001100, 8'h74, 1, 0);
    {is_hazard, mispredict, halt_req, i_ready, d_req, d_ready} = 6'b000100;
    #1 check("drain_pre", {24'd0, ctl}, 32'h7C);
    #2 reset_n = 1'b0;
    #1;
    check("arst.ctl", {24'd0, ctl}, 32'h0);
    check("arst.stall", stall_cnt, 32'd0);
    check("arst.flush", flush_cnt, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc("post_rst", 6'b000100, 8'hD4, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
